// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples SCK/SS/MOSI in the clk_i domain, shifts MSB first, and
// exposes a single-entry TX holding register plus an RX byte strobe to the bus wrapper.
module spi_slave #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = 8'hFF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_sck_i,
    input  logic                  spi_ss_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  tx_underrun_o
);
    localparam int unsigned     CntW    = $clog2(DATA_WIDTH);
    localparam int unsigned     ShW     = DATA_WIDTH - 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

    typedef enum logic {StIdle, StActive} state_e;

    // Bit 0 is the first synchroniser stage, bit 1 the second, bit 2 the history flop.
    logic [2:0] sck_sync_q, sck_sync_d;
    logic [2:0] ss_sync_q, ss_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;

    logic [1:0] settle_q, settle_d;
    logic       armed_q, armed_d;
    state_e     state_q, state_d;

    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [ShW-1:0]        rx_shift_q, rx_shift_d;
    logic [ShW-1:0]        tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  underrun_q, underrun_d;

    logic                  sck_rise, sck_fall, ss_rise, ss_fall, mosi_bit;
    logic                  tx_load, wr_accept;
    logic [DATA_WIDTH-1:0] load_byte;

    assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];
    assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
    assign mosi_bit  = mosi_sync_q[1];
    assign load_byte = tx_ready_q ? DEFAULT_TX : hold_q;
    assign wr_accept = tx_valid_i & tx_ready_q;

    always_comb begin
        sck_sync_d  = {sck_sync_q[1:0], spi_sck_i};
        ss_sync_d   = {ss_sync_q[1:0], spi_ss_i};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi_i};

        // SS only arms once the synchroniser holds a real post-reset high, so a select
        // held low through reset is not mistaken for a fresh fall.
        settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | ((settle_q == 2'd2) & ss_sync_q[1]);

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        hold_d     = hold_q;
        rx_data_d  = rx_data_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        tx_ready_d = tx_ready_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        tx_load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ss_fall && armed_q) begin
                    state_d   = StActive;
                    miso_oe_d = 1'b1;
                    tx_load   = 1'b1;
                end
            end
            StActive: begin
                if (ss_rise) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    miso_oe_d = 1'b0;
                    miso_d    = 1'b0;
                end else if (sck_rise) begin
                    rx_shift_d = ShW'({rx_shift_q, mosi_bit});
                    if (bit_cnt_q == CntLast) begin
                        rx_data_d  = {rx_shift_q, mosi_bit};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q == '0) begin
                        tx_load = 1'b1;
                    end else begin
                        miso_d     = tx_shift_q[ShW-1];
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
        endcase

        if (tx_load) begin
            miso_d     = load_byte[DATA_WIDTH-1];
            tx_shift_d = load_byte[ShW-1:0];
            underrun_d = tx_ready_q;
            tx_ready_d = 1'b1;
        end
        // A write in the same cycle as a load lands after it, ready for the next load.
        if (wr_accept) begin
            hold_d     = tx_data_i;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync_q  <= 3'b000;
            ss_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            rx_data_q   <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            tx_ready_q  <= 1'b1;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            rx_data_q   <= rx_data_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            tx_ready_q  <= tx_ready_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = miso_oe_q;
    assign tx_ready_o    = tx_ready_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed SPI master frames, a pin-history transaction model checked
// every cycle, and literal expectations for the bytes each frame must exchange.
module tb_spi_slave;
    localparam int LogSz = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, miso_oe, tx_ready, rx_valid, underrun;
    logic [7:0] rx_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_rxv = 0;
    int n_und = 0;

    spi_slave #(.DATA_WIDTH(8), .DEFAULT_TX(8'hFF)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .spi_sck_i    (sck),
        .spi_ss_i     (ss),
        .spi_mosi_i   (mosi),
        .spi_miso_o   (miso),
        .spi_miso_oe_o(miso_oe),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .tx_underrun_o(underrun)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pin values driven during each cycle; pin changes act on the outputs three edges later.
    logic       ss_l [LogSz];
    logic       sck_l[LogSz];
    logic       mo_l [LogSz];
    logic       rst_l[LogSz];
    logic       val_l[LogSz];
    logic [7:0] dat_l[LogSz];

    bit         m_init = 0, m_active, m_miso, m_oe, m_ready, m_rxv, m_und;
    logic [7:0] m_hold, m_byte, m_rx_acc, m_rxd;
    int         m_pos, m_rx_n, last_rst;

    initial begin : model
        int  n;
        bit  ss_e, ss_p, sck_e, sck_p, mo_e, ready_before, do_load;
        forever begin
            @(negedge clk);
            n = cyc;
            ss_l[n % LogSz]  = ss;
            sck_l[n % LogSz] = sck;
            mo_l[n % LogSz]  = mosi;
            rst_l[n % LogSz] = rst;
            val_l[n % LogSz] = tx_valid;
            dat_l[n % LogSz] = tx_data;
            if (n >= 5) begin
                m_rxv = 0;
                m_und = 0;
                if (rst_l[(n - 1) % LogSz]) begin
                    m_init = 1; last_rst = n - 1; m_active = 0; m_rx_n = 0; m_pos = 0;
                    m_miso = 0; m_oe = 0; m_ready = 1; m_hold = 0; m_rxd = 0; m_rx_acc = 0;
                end else if (m_init) begin
                    ready_before = m_ready;
                    do_load = 0;
                    if (n - 4 > last_rst) begin
                        ss_e  = ss_l[(n - 3) % LogSz];
                        ss_p  = ss_l[(n - 4) % LogSz];
                        sck_e = sck_l[(n - 3) % LogSz];
                        sck_p = sck_l[(n - 4) % LogSz];
                        mo_e  = mo_l[(n - 3) % LogSz];
                        if (!m_active) begin
                            if (ss_p && !ss_e) begin
                                m_active = 1; m_oe = 1; do_load = 1;
                            end
                        end else if (!ss_p && ss_e) begin
                            m_active = 0; m_oe = 0; m_miso = 0; m_rx_n = 0;
                        end else if (!sck_p && sck_e) begin
                            m_rx_acc = {m_rx_acc[6:0], mo_e};
                            m_rx_n++;
                            if (m_rx_n == 8) begin
                                m_rxd = m_rx_acc; m_rxv = 1; m_rx_n = 0;
                            end
                        end else if (sck_p && !sck_e) begin
                            if (m_rx_n == 0) do_load = 1;
                            else begin
                                m_pos++;
                                m_miso = m_byte[7 - m_pos];
                            end
                        end
                        if (do_load) begin
                            m_byte = m_ready ? 8'hFF : m_hold;
                            m_und = m_ready; m_ready = 1; m_pos = 0; m_miso = m_byte[7];
                        end
                    end
                    if (val_l[(n - 1) % LogSz] && ready_before) begin
                        m_hold = dat_l[(n - 1) % LogSz];
                        m_ready = 0;
                    end
                end
                if (m_init) begin
                    chk("miso", miso, m_miso);
                    chk("miso_oe", miso_oe, m_oe);
                    chk("tx_ready", tx_ready, m_ready);
                    chk("rx_valid", rx_valid, m_rxv);
                    chk("rx_data", rx_data, m_rxd);
                    chk("tx_underrun", underrun, m_und);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rx_valid === 1'b1) n_rxv++;
        if (underrun === 1'b1) n_und++;
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic ss_low();
        ss = 1'b0;
        tick(8);
    endtask

    task automatic tx_write(input logic [7:0] d);
        int t = 0;
        while (tx_ready !== 1'b1 && t < 200) begin tick(1); t++; end
        chk("tx_ready_wait", tx_ready, 1);
        tx_data = d; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Mode 0 master: MOSI set after each fall, MISO sampled just before each rise. When
    // end_frame is set the last fall and the SS release happen together.
    task automatic frame_bits(input logic [7:0] mo, input int nbits, input bit end_frame,
                              output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = mo[i];
            tick(4);
            mi[i] = miso;
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
            if (end_frame && i == 8 - nbits) ss = 1'b1;
        end
        mosi = 1'b0;
        if (end_frame) tick(8);
    endtask

    initial begin
        logic [7:0] got;
        rst = 1'b1;
        tick(6);
        rst = 1'b0;
        tick(8);
        chk("reset_miso", miso, 0);
        chk("reset_oe", miso_oe, 0);
        chk("reset_ready", tx_ready, 1);
        chk("reset_rx_data", rx_data, 8'h00);

        // Single byte
        n_rxv = 0; n_und = 0;
        tx_write(8'hA5); tick(2);
        chk("single_ready_full", tx_ready, 0);
        ss_low();
        chk("single_ready_after_load", tx_ready, 1);
        chk("single_oe", miso_oe, 1);
        frame_bits(8'h3C, 8, 1, got);
        chk("single_master_byte", got, 8'hA5);
        chk("single_rx_data", rx_data, 8'h3C);
        chk("single_rxv_count", n_rxv, 1);
        chk("single_underrun_count", n_und, 0);

        // Back-to-back
        n_rxv = 0; n_und = 0;
        tx_write(8'h12); tick(2);
        ss_low();
        tx_write(8'h34);
        frame_bits(8'hF0, 8, 0, got);
        chk("b2b_master_byte0", got, 8'h12);
        chk("b2b_rx_byte0", rx_data, 8'hF0);
        frame_bits(8'h0F, 8, 1, got);
        chk("b2b_master_byte1", got, 8'h34);
        chk("b2b_rx_byte1", rx_data, 8'h0F);
        chk("b2b_rxv_count", n_rxv, 2);
        chk("b2b_underrun_count", n_und, 0);

        // Underrun
        n_rxv = 0; n_und = 0;
        ss_low();
        chk("underrun_ready", tx_ready, 1);
        frame_bits(8'h6E, 8, 1, got);
        chk("underrun_master_byte", got, 8'hFF);
        chk("underrun_count", n_und, 1);
        chk("underrun_rx_data", rx_data, 8'h6E);

        // Abort after five bits
        n_rxv = 0; n_und = 0;
        ss_low();
        frame_bits(8'hF8, 5, 1, got);
        chk("abort_oe_released", miso_oe, 0);
        chk("abort_no_rxv", n_rxv, 0);
        chk("abort_rx_held", rx_data, 8'h6E);
        ss_low();
        frame_bits(8'h81, 8, 1, got);
        chk("abort_next_rx", rx_data, 8'h81);
        chk("abort_next_rxv", n_rxv, 1);
        chk("abort_next_master", got, 8'hFF);

        // Write coincident with the SS-fall load
        n_rxv = 0; n_und = 0;
        ss = 1'b0;
        tick(2);
        tx_data = 8'h55; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(5);
        frame_bits(8'h00, 8, 0, got);
        chk("simul_first_byte", got, 8'hFF);
        frame_bits(8'hAA, 8, 1, got);
        chk("simul_second_byte", got, 8'h55);
        chk("simul_underrun_count", n_und, 1);
        chk("simul_rx", rx_data, 8'hAA);

        // Reset mid-byte with SS held low through reset
        n_rxv = 0; n_und = 0;
        tx_write(8'h77); tick(2);
        ss_low();
        frame_bits(8'hC3, 3, 0, got);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);
        chk("midrst_oe", miso_oe, 0);
        chk("midrst_miso", miso, 0);
        chk("midrst_ready", tx_ready, 1);
        chk("midrst_rx_data", rx_data, 8'h00);
        ss = 1'b1;
        tick(8);
        ss_low();
        chk("midrst_oe_reselect", miso_oe, 1);
        frame_bits(8'h5A, 8, 1, got);
        chk("midrst_master_byte", got, 8'hFF);
        chk("midrst_rx", rx_data, 8'h5A);
        chk("midrst_rxv_count", n_rxv, 1);

        tick(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
